// File: rtl/Uop.sv
// Decoded micro-op types shared by the decode stage, issue control and the functional units.
package Uop;

  typedef enum logic [2:0] {
    EX_NONE     = 3'd0,
    EX_DECODE   = 3'd1,
    EX_ILLEGAL  = 3'd2,
    EX_MISALIGN = 3'd3,
    EX_FAULT    = 3'd4
  } ex_t;

  typedef struct packed {
    logic isLd;
    logic isSt;
  } mem_op_t;

  typedef struct packed {
    ex_t         ex;
    logic        exValid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        immValid;
    logic [31:0] imm;
    logic [2:0]  fu;
    logic [3:0]  op;
    mem_op_t     memOp;
    logic        flagsValid;
  } dec_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode-side, FU-side, writeback and status signals of issue_ctrl.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface issue_ctrl_if;
  logic          inValid;
  logic          inReady;
  Uop::dec_t     inDec;
  logic          outValid;
  logic          outReady;
  Uop::dec_t     outDec;
  logic          wbValid;
  logic [4:0]    wbRd;
  logic          memDone;
  logic          flush;
  logic          exRaised;
  Uop::ex_t      exCode;
  logic [15:0]   stallCount;
  Uop::state_t   state;

  modport slave (
    input  inValid, inDec, outReady, wbValid, wbRd, memDone, flush,
    output inReady, outValid, outDec, exRaised, exCode, stallCount, state
  );

  modport master (
    output inValid, inDec, outReady, wbValid, wbRd, memDone, flush,
    input  inReady, outValid, outDec, exRaised, exCode, stallCount, state
  );
endinterface

// File: rtl/issue_ctrl.sv
// Single-slot in-order issue stage: scoreboard RAW/WAW hazards, caps in-flight memory uops,
// and halts on an exception-flagged uop until flushed.
module issue_ctrl #(
  parameter int MEM_OUTSTANDING = 2
) (
  input  logic          clk,
  input  logic          rst,
  issue_ctrl_if.slave   bus
);
  import Uop::*;

  state_t      state_q, state_d;
  logic        slot_valid;
  dec_t        slot_dec;
  logic [31:0] pending, pending_eff, pending_d;
  logic [2:0]  mem_count;
  logic        ex_raised;
  ex_t         ex_code;
  logic [15:0] stall_count;

  logic run, is_mem, mem_full, hazard, out_valid, issue_fire, in_ready, in_fire;
  logic take_ex, stall, mem_inc, mem_dec;

  always_comb begin
    run         = (state_q == ST_RUN);
    pending_eff = pending;
    // A writeback in this cycle resolves the hazard immediately.
    if (bus.wbValid) pending_eff[bus.wbRd] = 1'b0;

    is_mem   = slot_dec.memOp.isLd | slot_dec.memOp.isSt;
    mem_full = (mem_count == 3'(MEM_OUTSTANDING));
    hazard   = ((slot_dec.rs1 != 5'd0) && pending_eff[slot_dec.rs1])
            || ((slot_dec.rs2 != 5'd0) && !slot_dec.immValid && pending_eff[slot_dec.rs2])
            || ((slot_dec.rd  != 5'd0) && pending_eff[slot_dec.rd])
            || (is_mem && mem_full);

    out_valid  = run && slot_valid && !slot_dec.exValid && !hazard;
    issue_fire = out_valid && bus.outReady;
    in_ready   = !rst && run && !bus.flush && (!slot_valid || issue_fire);
    in_fire    = bus.inValid && in_ready;
    take_ex    = run && slot_valid && slot_dec.exValid;
    stall      = run && slot_valid && !slot_dec.exValid && hazard;
    mem_inc    = issue_fire && is_mem;
    mem_dec    = bus.memDone && (mem_count != 3'd0);

    pending_d = pending_eff;
    if (issue_fire && (slot_dec.rd != 5'd0)) pending_d[slot_dec.rd] = 1'b1;
    pending_d[0] = 1'b0;

    state_d = state_q;
    if (take_ex) state_d = ST_HALT;
    if (bus.flush) state_d = ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      slot_valid  <= 1'b0;
      slot_dec    <= '0;
      pending     <= '0;
      mem_count   <= 3'd0;
      ex_raised   <= 1'b0;
      ex_code     <= EX_NONE;
      stall_count <= 16'd0;
    end else begin
      state_q <= state_d;

      if (bus.flush) begin
        slot_valid <= 1'b0;
        pending    <= '0;
        ex_raised  <= 1'b0;
        ex_code    <= EX_NONE;
      end else begin
        pending <= pending_d;
        if (take_ex) begin
          slot_valid <= 1'b0;
          ex_raised  <= 1'b1;
          ex_code    <= slot_dec.ex;
        end else if (in_fire) begin
          slot_valid <= 1'b1;
          slot_dec   <= bus.inDec;
        end else if (issue_fire) begin
          slot_valid <= 1'b0;
        end
      end

      // In-flight memory count survives flush; those uops are already in the FU.
      case ({mem_inc, mem_dec})
        2'b10:   mem_count <= mem_count + 3'd1;
        2'b01:   mem_count <= mem_count - 3'd1;
        default: mem_count <= mem_count;
      endcase

      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

  assign bus.inReady    = in_ready;
  assign bus.outValid   = out_valid;
  assign bus.outDec     = slot_dec;
  assign bus.exRaised   = ex_raised;
  assign bus.exCode     = ex_code;
  assign bus.stallCount = stall_count;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed scenarios followed by random traffic, all checked against a cycle-level reference model.
module tb_issue_ctrl;
  import Uop::*;

  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  issue_ctrl_if bus();

  issue_ctrl #(.MEM_OUTSTANDING(MO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [$bits(dec_t)-1:0] exp_q[$];

  // Reference model state
  bit        m_halt, m_slot_v, m_exr;
  dec_t      m_slot;
  bit [31:0] m_pend;
  int        m_mem, m_stall;
  ex_t       m_exc;
  bit        m_fire, m_haz, m_in_fire;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dec_t mk(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, bit imm_v,
                              bit ld, bit st, bit exv, ex_t ex);
    dec_t d;
    d            = '0;
    d.rd         = rd;
    d.rs1        = rs1;
    d.rs2        = rs2;
    d.immValid   = imm_v;
    d.imm        = $urandom;
    d.fu         = 3'($urandom_range(0, 7));
    d.op         = 4'($urandom_range(0, 15));
    d.memOp.isLd = ld;
    d.memOp.isSt = st;
    d.exValid    = exv;
    d.ex         = ex;
    d.flagsValid = 1'($urandom_range(0, 1));
    return d;
  endfunction

  function automatic bit model_hazard();
    bit [31:0] pe;
    bit busy;
    pe = m_pend;
    if (bus.wbValid) pe[bus.wbRd] = 1'b0;
    busy = 1'b0;
    if (m_slot.rs1 != 0 && pe[m_slot.rs1]) busy = 1'b1;
    if (!m_slot.immValid && m_slot.rs2 != 0 && pe[m_slot.rs2]) busy = 1'b1;
    if (m_slot.rd != 0 && pe[m_slot.rd]) busy = 1'b1;
    if ((m_slot.memOp.isLd || m_slot.memOp.isSt) && m_mem == MO) busy = 1'b1;
    return busy;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_slot_v = 0; m_exr = 0; m_slot = '0; m_pend = '0;
    m_mem = 0; m_stall = 0; m_exc = EX_NONE; m_fire = 0; m_haz = 0; m_in_fire = 0;
    exp_q.delete();
  endtask

  task automatic set_in(bit v, dec_t d, bit ordy, bit wbv, logic [4:0] wrd, bit md, bit fl);
    bus.inValid  = v;
    bus.inDec    = d;
    bus.outReady = ordy;
    bus.wbValid  = wbv;
    bus.wbRd     = wrd;
    bus.memDone  = md;
    bus.flush    = fl;
  endtask

  task automatic check_comb();
    bit exp_ov, exp_ir;
    #1;
    m_haz     = m_slot_v && model_hazard();
    exp_ov    = !m_halt && m_slot_v && !m_slot.exValid && !m_haz;
    m_fire    = exp_ov && bus.outReady;
    exp_ir    = !m_halt && !bus.flush && (!m_slot_v || m_fire);
    m_in_fire = exp_ir && bus.inValid;
    chk("in_ready", 64'(bus.inReady), 64'(exp_ir));
    chk("out_valid", 64'(bus.outValid), 64'(exp_ov));
    chk("ex_raised", 64'(bus.exRaised), 64'(m_exr));
    chk("ex_code", 64'(bus.exCode), 64'(m_exc));
    chk("stall_count", 64'(bus.stallCount), 64'(m_stall));
    chk("state", 64'(bus.state), 64'(m_halt));
    if (m_slot_v) chk("out_dec", 64'(bus.outDec), 64'(m_slot));
    if (m_fire) exp_q.push_back(m_slot);
    if (bus.outValid && bus.outReady && exp_q.size() != 0)
      chk("issued_uop", 64'(bus.outDec), 64'(exp_q.pop_front()));
  endtask

  task automatic tick();
    bit take_ex, is_mem;
    @(posedge clk);
    take_ex = !m_halt && m_slot_v && m_slot.exValid;
    is_mem  = m_slot.memOp.isLd || m_slot.memOp.isSt;
    if (!m_halt && m_slot_v && !m_slot.exValid && m_haz && m_stall < 65535) m_stall++;
    m_mem = m_mem + ((m_fire && is_mem) ? 1 : 0) - ((bus.memDone && m_mem > 0) ? 1 : 0);
    if (bus.flush) begin
      m_slot_v = 0; m_pend = '0; m_halt = 0; m_exr = 0; m_exc = EX_NONE;
    end else begin
      if (bus.wbValid) m_pend[bus.wbRd] = 1'b0;
      if (m_fire && m_slot.rd != 0) m_pend[m_slot.rd] = 1'b1;
      m_pend[0] = 1'b0;
      if (take_ex) begin
        m_halt = 1; m_exr = 1; m_exc = m_slot.ex; m_slot_v = 0;
      end else if (m_in_fire) begin
        m_slot = bus.inDec; m_slot_v = 1;
      end else if (m_fire) begin
        m_slot_v = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    check_comb();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.inReady), 64'd0);
    chk("rst_out_valid", 64'(bus.outValid), 64'd0);
    chk("rst_ex_raised", 64'(bus.exRaised), 64'd0);
    chk("rst_ex_code", 64'(bus.exCode), 64'd0);
    chk("rst_stall_count", 64'(bus.stallCount), 64'd0);
    chk("rst_out_dec", 64'(bus.outDec), 64'd0);
    chk("rst_state", 64'(bus.state), 64'(ST_RUN));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    dec_t nop, l1, l2, l3, hold_uop;
    nop = '0;
    set_in(0, nop, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    do_reset();

    // RAW stall resolved by same-cycle writeback
    set_in(1, mk(3, 1, 2, 0, 0, 0, 0, EX_NONE), 0, 0, 0, 0, 0); cyc();
    set_in(1, mk(4, 3, 0, 1, 0, 0, 0, EX_NONE), 1, 0, 0, 0, 0); cyc();
    set_in(0, nop, 1, 0, 0, 0, 0); repeat (3) cyc();
    set_in(0, nop, 1, 1, 5'd3, 0, 0);
    check_comb();
    chk("raw_stall_count", 64'(bus.stallCount), 64'd3);
    chk("raw_wb_bypass_issue", 64'(bus.outValid), 64'd1);
    tick();
    set_in(0, nop, 1, 0, 0, 0, 0); cyc();

    // Memory outstanding limit
    l1 = mk(10, 0, 0, 1, 1, 0, 0, EX_NONE);
    l2 = mk(11, 0, 0, 1, 1, 0, 0, EX_NONE);
    l3 = mk(12, 0, 0, 1, 1, 0, 0, EX_NONE);
    set_in(1, l1, 1, 0, 0, 0, 0); cyc();
    set_in(1, l2, 1, 0, 0, 0, 0); cyc();
    set_in(1, l3, 1, 0, 0, 0, 0); cyc();
    set_in(0, nop, 1, 0, 0, 0, 0);
    check_comb(); chk("mem_limit_stall", 64'(bus.outValid), 64'd0); tick();
    set_in(0, nop, 1, 0, 0, 1, 0);
    check_comb(); chk("mem_done_cycle_stalled", 64'(bus.outValid), 64'd0); tick();
    set_in(0, nop, 1, 0, 0, 0, 0);
    check_comb(); chk("mem_third_issues", 64'(bus.outValid), 64'd1); tick();
    set_in(0, nop, 1, 0, 0, 1, 0); repeat (2) cyc();

    // Exception halts until flush
    set_in(1, mk(6, 0, 0, 1, 0, 0, 1, EX_DECODE), 1, 0, 0, 0, 0); cyc();
    set_in(1, mk(7, 0, 0, 1, 0, 0, 0, EX_NONE), 1, 0, 0, 0, 0);
    check_comb();
    chk("ex_no_out_valid", 64'(bus.outValid), 64'd0);
    chk("ex_no_accept", 64'(bus.inReady), 64'd0);
    tick();
    check_comb();
    chk("ex_raised_set", 64'(bus.exRaised), 64'd1);
    chk("ex_code_decode", 64'(bus.exCode), 64'(EX_DECODE));
    chk("halt_in_ready", 64'(bus.inReady), 64'd0);
    tick();
    bus.flush = 1'b1; cyc();
    bus.flush = 1'b0;
    check_comb();
    chk("flush_clears_ex", 64'(bus.exRaised), 64'd0);
    chk("flush_resumes", 64'(bus.inReady), 64'd1);
    tick();

    // Issue rd=5 while writeback of r5: set wins
    set_in(1, mk(5, 0, 0, 1, 0, 0, 0, EX_NONE), 1, 0, 0, 0, 0); cyc();
    set_in(0, nop, 1, 1, 5'd5, 0, 0); cyc();
    set_in(1, mk(8, 5, 0, 1, 0, 0, 0, EX_NONE), 1, 0, 0, 0, 0); cyc();
    set_in(0, nop, 1, 0, 0, 0, 0);
    check_comb(); chk("set_wins_dependent_stall", 64'(bus.outValid), 64'd0); tick();
    set_in(0, nop, 1, 1, 5'd5, 0, 0); cyc();
    set_in(0, nop, 1, 0, 0, 0, 0); cyc();

    // Back-pressure hold, then reset mid-operation
    hold_uop = mk(9, 0, 0, 1, 0, 0, 0, EX_NONE);
    set_in(1, hold_uop, 0, 0, 0, 0, 0); cyc();
    set_in(1, mk(13, 0, 0, 1, 0, 0, 0, EX_NONE), 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check_comb();
      chk("hold_out_dec", 64'(bus.outDec), 64'(hold_uop));
      chk("hold_in_ready", 64'(bus.inReady), 64'd0);
      tick();
    end
    do_reset();
    set_in(1, mk(1, 0, 0, 1, 0, 0, 0, EX_NONE), 1, 0, 0, 0, 0);
    check_comb(); chk("post_reset_accept", 64'(bus.inReady), 64'd1); tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit ld, st, exv;
      int mk_sel;
      mk_sel = $urandom_range(0, 2);
      ld  = (mk_sel == 1);
      st  = (mk_sel == 2) && $urandom_range(0, 1);
      exv = ($urandom_range(0, 24) == 0);
      set_in(1'($urandom_range(0, 3) != 0),
             mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), ld, st, exv, ex_t'(3'($urandom_range(1, 4)))),
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 2) == 0),
             m_halt ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 49) == 0));
      cyc();
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter: MEM_OUTSTANDING, 2, max in-flight load/store uops (1..7).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: inValid  input  1  decoded uop offered by decode stage.
REQ-005 Port: inReady  output  1  issue_ctrl accepts uop this cycle.
REQ-006 Port: inDec  input  Uop::dec_t  decoded uop (fields ex, exValid, rd, rs1, rs2, immValid, imm, fu, op, memOp, flagsValid).
REQ-007 Port: outValid  output  1  uop offered to functional unit.
REQ-008 Port: outReady  input  1  functional unit accepts uop.
REQ-009 Port: outDec  output  Uop::dec_t  uop being issued (held slot contents).
REQ-010 Port: wbValid  input  1  register writeback this cycle.
REQ-011 Port: wbRd  input  5  writeback destination register.
REQ-012 Port: memDone  input  1  one outstanding memory uop completed.
REQ-013 Port: flush  input  1  synchronous pipeline flush.
REQ-014 Port: exRaised  output  1  sticky: exception-flagged uop reached issue.
REQ-015 Port: exCode  output  Uop::ex_t  ex field of the faulting uop.
REQ-016 Port: stallCount  output  16  hazard-stall cycle counter.

Function
REQ-017 State: one-entry slot (slotValid, slotDec), pending[31:0] scoreboard, memCount (3 bits), FSM {RUN, HALT}.
REQ-018 Accept: inFire = inValid && inReady; inReady = RUN && !flush && (!slotValid || issueFire); slot loads inDec on inFire, else clears on issueFire.
REQ-019 Hazard (combinational, against pendingEff = pending with wbRd bit cleared when wbValid): pendingEff[rs1] (rs1!=0), pendingEff[rs2] (rs2!=0, only if !immValid), pendingEff[rd] (rd!=0, WAW), or (memOp.isLd||memOp.isSt) && memCount==MEM_OUTSTANDING.
REQ-020 outValid = RUN && slotValid && !slotDec.exValid && !hazard; outValid SHALL NOT depend on outReady; outDec = slotDec always.
REQ-021 issueFire = outValid && outReady; zero-cycle latency slot-to-issue; back-to-back issue at 1 uop/cycle when hazard-free.
REQ-022 Scoreboard: wbValid clears pending[wbRd]; issueFire with rd!=0 sets pending[rd]; same-cycle set and clear of one bit -> set wins; pending[0] always 0.
REQ-023 memCount: +1 on issue of mem uop, -1 on memDone, unchanged if both; memDone at 0 ignored; never exceeds MEM_OUTSTANDING.
REQ-024 Exception: RUN && slotValid && slotDec.exValid -> next edge: HALT, exRaised=1, exCode=slotDec.ex, slot cleared; uop never issued.
REQ-025 HALT: inReady=0, outValid=0; wbValid and memDone still processed; exit only via flush or rst.
REQ-026 flush (highest priority): next edge slotValid=0, pending=0, state RUN, exRaised=0, exCode=0; memCount NOT cleared; inReady=0 and outValid unaffected combinationally only by RUN/slot rules but issueFire during flush cycle still counts for memCount.
REQ-027 stallCount: +1 each cycle RUN && slotValid && !slotDec.exValid && hazard (regardless of outReady); saturates at 16'hFFFF; cleared only by rst.
REQ-028 outReady low with outValid high: slot held, outDec stable, no scoreboard change.

Reset
REQ-029 rst asserted: immediately slotValid=0, pending=0, memCount=0, state RUN, exRaised=0, exCode=0, stallCount=0; hence inReady=0 during rst, outValid=0.
REQ-030 rst mid-operation discards slot and scoreboard; first accept possible on first edge after rst deasserts.

Verification
REQ-031 Issue ADD rd=3, then ADD rs1=3 with outReady=1 -> second stalls, stallCount increments per cycle; wbValid wbRd=3 -> second issues same cycle.
REQ-032 Three loads back-to-back, MEM_OUTSTANDING=2, no memDone -> two issue, third stalls; memDone pulse -> third issues next cycle, memCount stays 2.
REQ-033 Uop with exValid=1, ex=EX_DECODE -> never outValid; next cycle exRaised=1, exCode=EX_DECODE, inReady=0; flush -> exRaised=0, RUN.
REQ-034 Issue rd=5 while wbValid wbRd=5 same cycle -> pending[5]=1 afterwards.
REQ-035 outReady held 0 for 10 cycles with valid slot -> outDec constant, inReady=0, stallCount unchanged; rst asserted cycle 5 -> all outputs zero immediately.
